// File: rtl/simplespislave.sv
// -----------------------------------------------------------------------------
// simplespislave
//   SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, 8-bit frames) with an RX FIFO
//   and a TX FIFO. The CPU side uses one-cycle strobes. The SPI pins are
//   asynchronous to clk and are sampled through 2-flop synchronizers, so the
//   supported sck rate is clk/8 or slower.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   sck        SPI clock from the external master (asynchronous)
//   cs_n       SPI chip select, active low (asynchronous)
//   mosi       SPI data from the master (asynchronous)
//   miso       SPI data to the master; idles high while deselected
//   reg_tx_we  pulse: push reg_di[7:0] into the TX FIFO (ignored when full)
//   reg_rx_re  pulse: pop the RX FIFO head (ignored when empty)
//   reg_ctl_we pulse: [0] clear rx_overrun, [1] clear tx_underrun,
//              [2] flush both FIFOs
//   reg_di     CPU write data
//   reg_do     {19'b0, cs_active, tx_underrun, rx_overrun, tx_full,
//               rx_valid, rx_head}
//   irq        high while the RX FIFO holds data
// -----------------------------------------------------------------------------
module simplespislave #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        reg_tx_we,
  input  logic        reg_rx_re,
  input  logic        reg_ctl_we,
  input  logic [31:0] reg_di,
  output logic [31:0] reg_do,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;  // one extra wrap bit to tell full from empty

  // After reset the slave must first see cs_n high before it accepts a
  // falling edge; otherwise a master still holding cs_n low through reset
  // would look like a brand-new frame.
  typedef enum logic [1:0] {
    ST_UNARMED,
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t      state;
  logic [1:0]  sck_sync, cs_sync, mosi_sync;
  logic        sck_d, cs_d;
  logic [1:0]  sync_fill;  // marks when the synchronizers hold real pin data
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift, tx_shift, tx_shift_nxt;
  logic        rx_overrun, tx_underrun;

  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [7:0]  tx_mem [FIFO_DEPTH];
  ptr_t        rx_wr, rx_rd, tx_wr, tx_rd;

  // Synchronized pins and edge strobes.
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, live;
  assign sck_s    = sck_sync[1];
  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = (state == ST_IDLE) & cs_d & ~cs_s;
  assign live     = (state == ST_XFER) & ~cs_s;

  // FIFO status.
  logic rx_empty, rx_full, tx_empty, tx_full;
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);

  // RX path: the 8th rising edge completes a byte.
  logic [7:0] rx_byte;
  logic       spi_push, rx_pop_ok, rx_push_ok, rx_drop;
  assign rx_byte    = {rx_shift[6:0], mosi_s};
  assign spi_push   = live & sck_rise & (bit_cnt == 3'd7);
  assign rx_pop_ok  = reg_rx_re & ~rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_push_ok = spi_push & (~rx_full | rx_pop_ok);
  assign rx_drop    = spi_push & rx_full & ~rx_pop_ok;

  // TX path: load on frame start and on the falling edge closing each byte.
  // The FIFO state is the registered one, so a CPU push in the same cycle as
  // a load of an empty FIFO is not bypassed: 0xFF goes out, the byte stays.
  logic       tx_load, tx_pop_ok, tx_starve, tx_push_ok;
  logic [7:0] tx_load_val;
  assign tx_load     = cs_fall | (live & sck_fall & (bit_cnt == 3'd0));
  assign tx_pop_ok   = tx_load & ~tx_empty;
  assign tx_starve   = tx_load & tx_empty;
  assign tx_push_ok  = reg_tx_we & ~tx_full;
  assign tx_load_val = tx_empty ? 8'hFF : tx_mem[tx_rd[AW-1:0]];

  // Control decode.
  logic clr_ovr, clr_und, flush;
  assign clr_ovr = reg_ctl_we & reg_di[0];
  assign clr_und = reg_ctl_we & reg_di[1];
  assign flush   = reg_ctl_we & reg_di[2];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    tx_shift_nxt = tx_shift;
    if (tx_load)
      tx_shift_nxt = tx_load_val;
    else if (live && sck_fall)
      tx_shift_nxt = {tx_shift[6:0], 1'b0};
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync    <= 2'b00;
      cs_sync     <= 2'b11;
      mosi_sync   <= 2'b00;
      sck_d       <= 1'b0;
      cs_d        <= 1'b1;
      sync_fill   <= 2'b00;
      state       <= ST_UNARMED;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      miso        <= 1'b1;
      rx_wr       <= '0;
      rx_rd       <= '0;
      tx_wr       <= '0;
      tx_rd       <= '0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      sync_fill <= {sync_fill[0], 1'b1};

      case (state)
        ST_UNARMED: if (sync_fill[1] && cs_s) state <= ST_IDLE;
        ST_IDLE:    if (cs_fall) state <= ST_XFER;
        ST_XFER:    if (cs_s) state <= ST_IDLE;
        default:    state <= ST_UNARMED;
      endcase

      // Deselect (including mid-byte) drops the partial byte and the count.
      if (!live) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
      end

      tx_shift <= tx_shift_nxt;
      // Registered from next-state values so miso tracks tx_shift with no lag.
      miso     <= (live | cs_fall) ? tx_shift_nxt[7] : 1'b1;

      if (flush) begin
        rx_wr <= '0;
        rx_rd <= '0;
        tx_wr <= '0;
        tx_rd <= '0;
      end else begin
        if (rx_push_ok) rx_wr <= rx_wr + ptr_t'(1);
        if (rx_pop_ok)  rx_rd <= rx_rd + ptr_t'(1);
        if (tx_push_ok) tx_wr <= tx_wr + ptr_t'(1);
        if (tx_pop_ok)  tx_rd <= tx_rd + ptr_t'(1);
      end

      // Sticky flags; a same-cycle set wins over a clear.
      rx_overrun  <= (rx_overrun  & ~clr_ovr) | rx_drop;
      tx_underrun <= (tx_underrun & ~clr_und) | tx_starve;
    end
  end

  // NOTE: FIFO storage has no reset; emptiness is defined by the pointers,
  // and the readback masks the head to 0x00 while the RX FIFO is empty.
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wr[AW-1:0]] <= rx_byte;
    if (tx_push_ok) tx_mem[tx_wr[AW-1:0]] <= reg_di[7:0];
  end

  logic       rx_valid;
  logic [7:0] rx_head;
  assign rx_valid = ~rx_empty;
  assign rx_head  = rx_valid ? rx_mem[rx_rd[AW-1:0]] : 8'h00;
  assign irq      = rx_valid;
  assign reg_do   = {19'd0, ~cs_s, tx_underrun, rx_overrun, tx_full, rx_valid, rx_head};

  logic unused_di;
  assign unused_di = ^reg_di[31:8];

endmodule

// File: tb/tb_simplespislave.sv
// -----------------------------------------------------------------------------
// tb_simplespislave
//   Drives simplespislave as an SPI mode-0 master (sck = clk/8) and as a CPU.
//   Expected values come from a directed table of constants and from a
//   transaction-level model built on queues.
// -----------------------------------------------------------------------------
module tb_simplespislave;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, sck, cs_n, mosi, miso;
  logic        reg_tx_we, reg_rx_re, reg_ctl_we;
  logic [31:0] reg_di, reg_do;
  logic        irq;

  simplespislave #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .reg_tx_we(reg_tx_we), .reg_rx_re(reg_rx_re),
    .reg_ctl_we(reg_ctl_we), .reg_di(reg_di), .reg_do(reg_do), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  logic       m_ovr, m_und;

  function automatic logic [31:0] m_status();
    logic [7:0] head;
    head = (m_rx.size() > 0) ? m_rx[0] : 8'h00;
    return {19'd0, 1'b0, m_und, m_ovr, (m_tx.size() == DEPTH), (m_rx.size() > 0), head};
  endfunction

  function automatic logic [7:0] m_load();
    logic [7:0] b;
    if (m_tx.size() == 0) begin
      m_und = 1'b1;
      b = 8'hFF;
    end else begin
      b = m_tx[0];
      m_tx.delete(0);
    end
    return b;
  endfunction

  function automatic void m_rx_push(input logic [7:0] b);
    if (m_rx.size() == DEPTH) m_ovr = 1'b1;
    else m_rx.push_back(b);
  endfunction

  function automatic void m_reset();
    m_rx.delete();
    m_tx.delete();
    m_ovr = 1'b0;
    m_und = 1'b0;
  endfunction

  logic [7:0] xb[8];     // bytes the master sends
  logic [7:0] got[8];    // bytes captured from miso
  logic [7:0] exp_b[8];  // model prediction of miso bytes

  // One frame: nfull whole bytes followed by npart bits of one more byte.
  // Coincident CPU actions on the frame-start load are applied load-first
  // for pushes and clear-first for control writes.
  function automatic void m_xfer(input int nfull, input bit pop_last,
                                 input bit we_at_load, input bit ctl_at_load,
                                 input logic [7:0] load_di);
    if (ctl_at_load) begin
      if (load_di[0]) m_ovr = 1'b0;
      if (load_di[1]) m_und = 1'b0;
    end
    exp_b[0] = m_load();
    if (we_at_load && m_tx.size() < DEPTH) m_tx.push_back(load_di);
    for (int i = 0; i < nfull; i++) begin
      if (pop_last && i == nfull - 1 && m_rx.size() > 0) m_rx.delete(0);
      m_rx_push(xb[i]);
      exp_b[i + 1] = m_load();
    end
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic check_state(input string name);
    check({name, " reg_do"}, reg_do, m_status());
    check({name, " irq"}, 32'(irq), 32'(m_rx.size() > 0));
  endtask

  task automatic cpu_push(input logic [7:0] b);
    reg_di = {24'd0, b};
    reg_tx_we = 1'b1;
    @(negedge clk);
    reg_tx_we = 1'b0;
    reg_di = '0;
    if (m_tx.size() < DEPTH) m_tx.push_back(b);
  endtask

  task automatic cpu_pop();
    reg_rx_re = 1'b1;
    @(negedge clk);
    reg_rx_re = 1'b0;
    if (m_rx.size() > 0) m_rx.delete(0);
  endtask

  task automatic cpu_ctl(input logic [2:0] v);
    reg_di = {29'd0, v};
    reg_ctl_we = 1'b1;
    @(negedge clk);
    reg_ctl_we = 1'b0;
    reg_di = '0;
    if (v[0]) m_ovr = 1'b0;
    if (v[1]) m_und = 1'b0;
    if (v[2]) begin
      m_rx.delete();
      m_tx.delete();
    end
  endtask

  task automatic sck_pulse();
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Master frame. Frame-start load happens 3 clocks after cs_n falls; the
  // coincident strobes are timed to that clock. pop_last lands a CPU pop on
  // the clock where the final whole byte is pushed.
  task automatic spi_xfer(input int nfull, input int npart, input bit pop_last,
                          input bit we_at_load, input bit ctl_at_load,
                          input logic [7:0] load_di);
    int nb;
    nb = nfull + ((npart > 0) ? 1 : 0);
    for (int i = 0; i < 8; i++) got[i] = 8'h00;
    cs_n = 1'b0;
    mosi = xb[0][7];
    repeat (2) @(negedge clk);
    if (we_at_load) begin reg_di = {24'd0, load_di}; reg_tx_we = 1'b1; end
    if (ctl_at_load) begin reg_di = {24'd0, load_di}; reg_ctl_we = 1'b1; end
    @(negedge clk);
    reg_tx_we = 1'b0;
    reg_ctl_we = 1'b0;
    reg_di = '0;
    @(negedge clk);
    check("cs_active", 32'(reg_do[12]), 32'd1);
    for (int i = 0; i < nb; i++) begin
      int nbits;
      nbits = (i < nfull) ? 8 : npart;
      for (int j = 0; j < nbits; j++) begin
        got[i][7 - j] = miso;
        sck = 1'b1;
        if (pop_last && i == nfull - 1 && j == 7) begin
          repeat (2) @(negedge clk);
          reg_rx_re = 1'b1;
          @(negedge clk);
          reg_rx_re = 1'b0;
          @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
        sck = 1'b0;
        if (j < 7) mosi = xb[i][6 - j];
        else if (i + 1 < nb) mosi = xb[i + 1][7];
        else mosi = 1'b0;
        repeat (4) @(negedge clk);
      end
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Model + DUT frame, then compare miso bytes and status.
  task automatic do_xfer(input string name, input int nfull, input int npart,
                         input bit pop_last, input bit we_at_load,
                         input bit ctl_at_load, input logic [7:0] load_di);
    logic [7:0] mask;
    m_xfer(nfull, pop_last, we_at_load, ctl_at_load, load_di);
    spi_xfer(nfull, npart, pop_last, we_at_load, ctl_at_load, load_di);
    for (int i = 0; i < nfull; i++)
      check({name, " miso"}, 32'(got[i]), 32'(exp_b[i]));
    if (npart > 0) begin
      mask = 8'hFF << (8 - npart);
      check({name, " miso partial"}, 32'(got[nfull] & mask), 32'(exp_b[nfull] & mask));
    end
    check_state(name);
  endtask

  // ---------------- directed table ----------------
  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_CTL, OP_XFER} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  din;       // push data, ctl bits, or first mosi byte
    int          nb;        // bytes in a transfer (mosi = din, din+1, ...)
    logic [7:0]  exp_miso;  // expected on every byte of the transfer
    logic [12:0] exp_do;    // expected reg_do[12:0] afterwards (cs high)
  } vec_t;

  vec_t tbl[24];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    reg_tx_we = 1'b0; reg_rx_re = 1'b0; reg_ctl_we = 1'b0; reg_di = '0;
    m_reset();

    tbl = '{
      '{OP_PUSH, 8'hA5, 0, 8'h00, 13'h000},
      '{OP_XFER, 8'h3C, 1, 8'hA5, 13'h93C},
      '{OP_POP,  8'h00, 0, 8'h00, 13'h800},
      '{OP_CTL,  8'h02, 0, 8'h00, 13'h000},
      '{OP_XFER, 8'h11, 2, 8'hFF, 13'h911},
      '{OP_CTL,  8'h02, 0, 8'h00, 13'h111},
      '{OP_CTL,  8'h04, 0, 8'h00, 13'h000},
      '{OP_XFER, 8'h01, 5, 8'hFF, 13'hD01},
      '{OP_POP,  8'h00, 0, 8'h00, 13'hD02},
      '{OP_POP,  8'h00, 0, 8'h00, 13'hD03},
      '{OP_POP,  8'h00, 0, 8'h00, 13'hD04},
      '{OP_POP,  8'h00, 0, 8'h00, 13'hC00},
      '{OP_POP,  8'h00, 0, 8'h00, 13'hC00},
      '{OP_CTL,  8'h03, 0, 8'h00, 13'h000},
      '{OP_PUSH, 8'h11, 0, 8'h00, 13'h000},
      '{OP_PUSH, 8'h22, 0, 8'h00, 13'h000},
      '{OP_PUSH, 8'h33, 0, 8'h00, 13'h000},
      '{OP_PUSH, 8'h44, 0, 8'h00, 13'h200},
      '{OP_PUSH, 8'h55, 0, 8'h00, 13'h200},
      '{OP_XFER, 8'hC3, 1, 8'h11, 13'h1C3},
      '{OP_XFER, 8'h5A, 1, 8'h33, 13'h1C3},
      '{OP_XFER, 8'h7E, 1, 8'hFF, 13'h9C3},
      '{OP_CTL,  8'h04, 0, 8'h00, 13'h800},
      '{OP_CTL,  8'h02, 0, 8'h00, 13'h000}
    };

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset reg_do", reg_do, 32'd0);
    check("reset miso", 32'(miso), 32'd1);
    check("reset irq", 32'(irq), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Directed table.
    for (int t = 0; t < 24; t++) begin
      case (tbl[t].op)
        OP_PUSH: cpu_push(tbl[t].din);
        OP_POP:  cpu_pop();
        OP_CTL:  cpu_ctl(tbl[t].din[2:0]);
        default: begin
          for (int k = 0; k < tbl[t].nb; k++) xb[k] = tbl[t].din + 8'(k);
          m_xfer(tbl[t].nb, 1'b0, 1'b0, 1'b0, 8'h00);
          spi_xfer(tbl[t].nb, 0, 1'b0, 1'b0, 1'b0, 8'h00);
          for (int k = 0; k < tbl[t].nb; k++)
            check($sformatf("tbl[%0d] miso byte %0d", t, k), 32'(got[k]), 32'(tbl[t].exp_miso));
        end
      endcase
      check($sformatf("tbl[%0d] reg_do", t), reg_do, {19'd0, tbl[t].exp_do});
      check($sformatf("tbl[%0d] irq", t), 32'(irq), 32'(tbl[t].exp_do[8]));
    end

    // Deselect after 5 bits: no push, next whole byte intact.
    xb[0] = 8'hE7;
    do_xfer("abort5", 0, 5, 1'b0, 1'b0, 1'b0, 8'h00);
    xb[0] = 8'h81;
    do_xfer("after abort", 1, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    cpu_pop();
    check_state("after abort pop");
    cpu_ctl(3'b011);

    // Pop coincident with the push into a full RX FIFO.
    for (int k = 0; k < 4; k++) xb[k] = 8'hA0 + 8'(k);
    do_xfer("fill rx", 4, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    xb[0] = 8'hB7;
    do_xfer("pop+push full", 1, 0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cpu_pop();
      check_state("drain rx");
    end
    cpu_ctl(3'b011);

    // CPU push coincident with load of an empty TX FIFO: no bypass.
    xb[0] = 8'h10; xb[1] = 8'h20;
    do_xfer("push at load", 2, 0, 1'b0, 1'b1, 1'b0, 8'h6D);
    cpu_ctl(3'b011);
    check_state("clear flags");
    // Underrun clear coincident with an underrun set: the set wins.
    xb[0] = 8'h00;
    do_xfer("clear vs set", 0, 3, 1'b0, 1'b0, 1'b1, 8'h02);
    cpu_ctl(3'b011);

    // Reset in the middle of a frame.
    xb[0] = 8'h99;
    do_xfer("pre-reset", 1, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    cs_n = 1'b0;
    mosi = 1'b1;
    repeat (4) @(negedge clk);
    repeat (3) sck_pulse();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    m_reset();
    check("mid reset reg_do", reg_do, 32'd0);
    check("mid reset miso", 32'(miso), 32'd1);
    check("mid reset irq", 32'(irq), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    repeat (8) sck_pulse();
    check("post reset cs held reg_do", reg_do, 32'h0000_1000);
    check("post reset cs held miso", 32'(miso), 32'd1);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    xb[0] = 8'h55;
    do_xfer("post reset 0x55", 1, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    cpu_ctl(3'b111);

    // Randomized operations against the model.
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        cpu_push(8'($urandom));
        check_state("rand push");
      end else if (r <= 5) begin
        cpu_pop();
        check_state("rand pop");
      end else if (r <= 8) begin
        int nf, np;
        nf = $urandom_range(1, 3);
        np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        for (int k = 0; k < 8; k++) xb[k] = 8'($urandom);
        do_xfer("rand xfer", nf, np, 1'b0, 1'b0, 1'b0, 8'h00);
      end else begin
        cpu_ctl(3'($urandom_range(0, 7)));
        check_state("rand ctl");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simplespislave.md
SIMPLESPISLAVE -- requirements
Module: simplespislave

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning entries per RX and TX FIFO (power of two, >=2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sck  input  1  SPI clock from external master, asynchronous to clk.
REQ-005 SHALL have port cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-006 SHALL have port mosi  input  1  SPI data from master, asynchronous.
REQ-007 SHALL have port miso  output  1  SPI data to master.
REQ-008 SHALL have port reg_tx_we  input  1  one-cycle pulse; push reg_di[7:0] into TX FIFO.
REQ-009 SHALL have port reg_rx_re  input  1  one-cycle pulse; pop RX FIFO head.
REQ-010 SHALL have port reg_ctl_we  input  1  one-cycle pulse; control write using reg_di[2:0].
REQ-011 SHALL have port reg_di  input  32  CPU write data.
REQ-012 SHALL have port reg_do  output  32  status/data readback.
REQ-013 SHALL have port irq  output  1  high while RX FIFO non-empty.

Function
REQ-014 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
REQ-015 SHALL pass sck, cs_n, mosi through 2-flop synchronizers; edges detected from synchronized sck/cs_n; supported sck <= clk/8.
REQ-016 SHALL, while synchronized cs_n high: bit counter held 0, miso = 1, no shifting.
REQ-017 SHALL, on synchronized cs_n falling edge: load TX shift register from TX FIFO head and pop; if TX FIFO empty, load 0xFF and set tx_underrun.
REQ-018 SHALL, on each sck rising edge with cs_n low: shift synchronized mosi into RX shift register LSB, bit counter +1 (3-bit, wraps 7->0).
REQ-019 SHALL, on 8th rising edge (counter wraps to 0): push assembled byte into RX FIFO; if full, drop byte and set rx_overrun.
REQ-020 SHALL, on each sck falling edge with cs_n low: shift TX register left; when bit counter is 0, instead reload from TX FIFO per REQ-017 rules.
REQ-021 SHALL drive miso = TX shift register bit 7 while cs_n low, registered.
REQ-022 SHALL, on cs_n rising mid-byte: discard partial RX byte (no push), reset bit counter, discard loaded TX byte (not re-queued).
REQ-023 SHALL ignore reg_tx_we when TX FIFO full (byte lost, no flag); ignore reg_rx_re when RX FIFO empty.
REQ-024 SHALL, on simultaneous SPI push and CPU pop of full RX FIFO: perform both, no overrun.
REQ-025 SHALL, on simultaneous CPU push and SPI load of empty TX FIFO: no bypass; send 0xFF, set tx_underrun, pushed byte remains queued.
REQ-026 SHALL decode reg_ctl_we: reg_di[0]=1 clears rx_overrun, reg_di[1]=1 clears tx_underrun, reg_di[2]=1 flushes both FIFOs; flag clear loses to same-cycle set.
REQ-027 SHALL drive reg_do combinationally: [7:0] RX head (0x00 if empty), [8] rx_valid, [9] tx_full, [10] rx_overrun, [11] tx_underrun, [12] ~cs_n synchronized, [31:13] 0.
REQ-028 SHALL keep rx_overrun and tx_underrun sticky until cleared per REQ-026 or reset.
REQ-029 SHALL drive irq = rx_valid (registered FIFO state, no extra latency).

Reset
REQ-030 SHALL, on reset: both FIFOs empty, flags 0, bit counter 0, shift registers 0, synchronizers to sck=0/cs_n=1/mosi=0, miso=1, irq=0, reg_do=0.
REQ-031 SHALL, if reset asserted mid-transfer, abandon transfer; resume only after next cs_n falling edge following reset release.

Verification
REQ-032 SHALL verify: CPU pushes 0xA5; master clocks 0x3C with sck=clk/8 -> miso shows 1010_0101 MSB first, reg_do[8:0]=0x13C, irq=1.
REQ-033 SHALL verify: empty TX FIFO, 2-byte transfer -> miso all ones, reg_do[11]=1; ctl write 0x2 -> reg_do[11]=0.
REQ-034 SHALL verify: master sends FIFO_DEPTH+1 bytes (0x01..0x05), no CPU pops -> RX holds 0x01..0x04, reg_do[10]=1; 4 pops return 0x01..0x04 then irq=0.
REQ-035 SHALL verify: cs_n deasserted after 5 bits -> no RX push, next full byte 0x81 received intact.
REQ-036 SHALL verify: RX full, pop coincident with 8th rising edge -> no overrun, newest byte at tail.
REQ-037 SHALL verify: reset asserted after 3 bits -> reg_do=0, miso=1; following full transfer of 0x55 received correctly.
